// File: rtl/taylor_term_gen_if.sv
// rtl/taylor_term_gen_if.sv - init/argument inputs and term/count outputs of the Taylor term generator.
interface taylor_term_gen_if;
  logic        init;
  logic [1:0]  MOD;
  logic [15:0] x;
  logic [15:0] term;
  logic [2:0]  count;
  logic        Done;
  logic        co;
  logic        busy;

  modport master (output init, MOD, x, input term, count, Done, co, busy);
  modport slave  (input init, MOD, x, output term, count, Done, co, busy);
endinterface

// File: rtl/taylor_term_gen.sv
// rtl/taylor_term_gen.sv - serial generator of Q2.14 Taylor terms x^k/k!, k = 0..7.
// Optional macro TAYLOR_SIGN_ALT_EN: negate emitted terms of cos/sin when k mod 4 is 2 or 3.
module taylor_term_gen (
  input  logic            clk,
  input  logic            rst,
  taylor_term_gen_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD0, MULX, MULR, EMIT} state_t;

  state_t      state, state_nx;
  logic [15:0] x_q;
  logic [1:0]  mod_q;
  logic [15:0] acc_mag;
  logic        acc_sign;
  logic [15:0] mcand;
  logic [31:0] prod;
  logic [3:0]  step;
  logic [15:0] term_q;
  logic [2:0]  count_q;
  logic        done_q;
  logic        busy_c;

  logic [16:0] sum;
  logic [31:0] prod_nx;
  logic        last_step;
  logic [2:0]  k_nx;
  logic [15:0] recip;
  logic [15:0] x_mag;
  logic [15:0] mulx_mag;
  logic [15:0] mulr_mag;
  logic        mulx_sign;
  logic        alt;
  logic        emit_sign;
  logic [15:0] emit_val;

`ifndef TAYLOR_SIGN_ALT_EN
  logic unused_mod;
  assign unused_mod = ^mod_q;
`endif

  // Shift-add step: multiplier sits in prod[15:0], partial product grows from the top.
  always_comb begin
    sum       = {1'b0, prod[31:16]} + (prod[0] ? {1'b0, mcand} : 17'd0);
    prod_nx   = {sum, prod[15:1]};
    last_step = (step == 4'd15);
    k_nx      = count_q + 3'd1;
    x_mag     = x_q[15] ? (~x_q + 16'd1) : x_q;
    mulx_mag  = prod_nx[29:14];
    mulr_mag  = prod_nx[31:16];
    mulx_sign = (mulx_mag != 16'd0) && (acc_sign ^ x_q[15]);
    case (k_nx)
      3'd2:    recip = 16'h8000;
      3'd3:    recip = 16'h5555;
      3'd4:    recip = 16'h4000;
      3'd5:    recip = 16'h3333;
      3'd6:    recip = 16'h2AAB;
      3'd7:    recip = 16'h2492;
      default: recip = 16'h0000;
    endcase
`ifdef TAYLOR_SIGN_ALT_EN
    alt = (mod_q != 2'd0) && k_nx[1];
`else
    alt = 1'b0;
`endif
    emit_sign = acc_sign ^ alt;
    emit_val  = (emit_sign && (acc_mag != 16'd0)) ? (~acc_mag + 16'd1) : acc_mag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    case (state)
      IDLE:  state_nx = IDLE;
      LOAD0: state_nx = MULX;
      MULX: begin
        busy_c = 1'b1;
        if (last_step) state_nx = (k_nx == 3'd1) ? EMIT : MULR;
      end
      MULR: begin
        busy_c = 1'b1;
        if (last_step) state_nx = EMIT;
      end
      EMIT:    state_nx = (k_nx == 3'd7) ? IDLE : MULX;
      default: state_nx = IDLE;
    endcase
    // A restart wins over everything, including an in-flight term.
    if (bus.init) state_nx = LOAD0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= 16'd0;
      mod_q    <= 2'd0;
      acc_mag  <= 16'd0;
      acc_sign <= 1'b0;
      mcand    <= 16'd0;
      prod     <= 32'd0;
      step     <= 4'd0;
      term_q   <= 16'd0;
      count_q  <= 3'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.init) begin
        x_q   <= bus.x;
        mod_q <= bus.MOD;
      end else begin
        case (state)
          LOAD0: begin
            term_q   <= 16'h4000;
            count_q  <= 3'd0;
            done_q   <= 1'b1;
            acc_mag  <= 16'h4000;
            acc_sign <= 1'b0;
            mcand    <= 16'h4000;
            prod     <= {16'd0, x_mag};
            step     <= 4'd0;
          end
          MULX: begin
            prod <= prod_nx;
            step <= step + 4'd1;
            if (last_step) begin
              acc_mag  <= mulx_mag;
              acc_sign <= mulx_sign;
              mcand    <= mulx_mag;
              prod     <= {16'd0, recip};
            end
          end
          MULR: begin
            prod <= prod_nx;
            step <= step + 4'd1;
            if (last_step) begin
              acc_mag <= mulr_mag;
              if (mulr_mag == 16'd0) acc_sign <= 1'b0;
            end
          end
          EMIT: begin
            term_q  <= emit_val;
            count_q <= k_nx;
            done_q  <= 1'b1;
            mcand   <= acc_mag;
            prod    <= {16'd0, x_mag};
            step    <= 4'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.term  = term_q;
  assign bus.count = count_q;
  assign bus.Done  = done_q;
  assign bus.co    = (count_q == 3'd7);
  assign bus.busy  = busy_c;

endmodule

// File: tb/tb_taylor_term_gen.sv
// tb/tb_taylor_term_gen.sv - directed self-checking bench for taylor_term_gen.
module tb_taylor_term_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  taylor_term_gen_if bus();
  taylor_term_gen dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] xv, input logic [1:0] mv);
    @(negedge clk);
    bus.init = 1'b1;
    bus.x    = xv;
    bus.MOD  = mv;
    @(negedge clk);
    bus.init = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.Done !== 1'b1 && n < 100);
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 17 : 33);
  endfunction

  logic [15:0] exp27 [8];
  int n;
  int extra;

  initial begin
    exp27 = '{16'h4000, 16'h4000, 16'h2000, 16'h0AAA, 16'h02AA, 16'h0088, 16'h0016, 16'h0003};
    bus.init = 1'b0;
    bus.x    = 16'd0;
    bus.MOD  = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_term", bus.term, 16'h0000);
    check("rst_count", bus.count, 3'd0);
    check("rst_done", bus.Done, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_co", bus.co, 1'b0);
    rst = 1'b1;

    // e^x at x = 1.0: full series, latencies, co only at k7, hold after the end
    start(16'h4000, 2'd0);
    for (int k = 0; k < 8; k++) begin
      wait_done(n);
      check($sformatf("e1_lat_k%0d", k), n, lat_of(k) - ((k == 1) ? 1 : 0));
      check($sformatf("e1_term_k%0d", k), bus.term, exp27[k]);
      check($sformatf("e1_count_k%0d", k), bus.count, k);
      check($sformatf("e1_co_k%0d", k), bus.co, (k == 7) ? 1'b1 : 1'b0);
      if (k == 0) begin
        @(negedge clk);
        check("e1_done_one_cycle", bus.Done, 1'b0);
        check("e1_term_stable", bus.term, 16'h4000);
        check("e1_busy_mulx", bus.busy, 1'b1);
      end
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done === 1'b1) extra++;
    end
    check("e1_idle_no_done", extra, 0);
    check("e1_idle_term", bus.term, 16'h0003);
    check("e1_idle_count", bus.count, 3'd7);
    check("e1_idle_co", bus.co, 1'b1);
    check("e1_idle_busy", bus.busy, 1'b0);

    // e^x at x = -1.0: signs alternate through the accumulator
    start(16'hC000, 2'd0);
    wait_done(n);
    wait_done(n);
    check("neg_term_k1", bus.term, 16'hC000);
    wait_done(n);
    check("neg_term_k2", bus.term, 16'h2000);
    wait_done(n);
    check("neg_term_k3", bus.term, 16'hF556);

    // sin at x = 1.0
    start(16'h4000, 2'd2);
    for (int k = 0; k < 6; k++) begin
      wait_done(n);
`ifdef TAYLOR_SIGN_ALT_EN
      if (k == 2) check("sin_term_k2", bus.term, 16'hE000);
      if (k == 3) check("sin_term_k3", bus.term, 16'hF556);
`else
      if (k == 2) check("sin_term_k2", bus.term, 16'h2000);
      if (k == 3) check("sin_term_k3", bus.term, 16'h0AAA);
`endif
      if (k == 5) check("sin_term_k5", bus.term, 16'h0088);
    end

    // restart 10 cycles into MULR of k = 4
    start(16'h4000, 2'd0);
    repeat (4) wait_done(n);
    repeat (26) @(negedge clk);
    check("abort_busy_mulr", bus.busy, 1'b1);
    check("abort_hold_count", bus.count, 3'd3);
    start(16'h4000, 2'd0);
    wait_done(n);
    check("abort_lat", n, 1);
    check("abort_count", bus.count, 3'd0);
    check("abort_term", bus.term, 16'h4000);

    // reset during MULX with count = 3
    start(16'h4000, 2'd0);
    repeat (4) wait_done(n);
    repeat (5) @(negedge clk);
    check("rmid_busy", bus.busy, 1'b1);
    rst = 1'b0;
    #1;
    check("rmid_term", bus.term, 16'h0000);
    check("rmid_count", bus.count, 3'd0);
    check("rmid_done", bus.Done, 1'b0);
    check("rmid_busy_low", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.Done === 1'b1) extra++;
    end
    check("rmid_no_resume", extra, 0);

    // x = 0: only k0 is non-zero
    start(16'h0000, 2'd0);
    for (int k = 0; k < 8; k++) begin
      wait_done(n);
      check($sformatf("z_lat_k%0d", k), n, lat_of(k));
      check($sformatf("z_term_k%0d", k), bus.term, (k == 0) ? 16'h4000 : 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
